// File: rtl/loader_pkg.sv
// Shared encodings for the serial instruction-memory loader.
package loader_pkg;
    typedef enum logic [2:0] {S_CNTL, S_CNTH, S_DATA, S_SUM, S_DONE, S_ERR} ld_state_e;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    localparam int BIDX_W = 2;
endpackage

// File: rtl/m_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/framing pulses.
module m_uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frame_err_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             vld_q, vld_d, fe_q, fe_d;
    logic [2:0]       sync_q;
    logic             rx_s, rx_prev;

    // sync_q[1] is the synchronized line; sync_q[2] is its previous value for edge detect
    assign rx_s    = sync_q[1];
    assign rx_prev = sync_q[2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = CNT_W'(1);
                if (rx_prev && !rx_s) state_d = R_START;
            end
            R_START: if (cnt_q == HALF) begin
                cnt_d   = CNT_W'(1);
                bit_d   = 3'd0;
                state_d = rx_s ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt_q == FULL) begin
                cnt_d   = CNT_W'(1);
                shift_d = {rx_s, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'd7) state_d = R_STOP;
            end
            R_STOP: if (cnt_q == FULL) begin
                state_d = R_IDLE;
                vld_d   = rx_s;
                fe_d    = !rx_s;
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= 3'b111;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            vld_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rxd_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            fe_q    <= fe_d;
        end
    end

    assign byte_o      = shift_q;
    assign byte_vld_o  = vld_q;
    assign frame_err_o = fe_q;
endmodule

// File: rtl/m_imem_loader.sv
// UART program loader: header count, big-endian word assembly, imem write port, CPU reset hold.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module m_imem_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 12
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_rxd,
    output logic              r_we,
    output logic [ADDR_W-1:0] r_addr,
    output logic [31:0]       r_wdata,
    output logic              r_busy,
    output logic              r_done,
    output logic              r_err
);
    logic [7:0] rx_byte;
    logic       rx_vld, rx_fe;

    m_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i      (w_clk),
        .rst_ni     (w_rst_n),
        .rxd_i      (w_rxd),
        .byte_o     (rx_byte),
        .byte_vld_o (rx_vld),
        .frame_err_o(rx_fe)
    );

    ld_state_e         state_q, state_d;
    logic [BIDX_W-1:0] bidx_q;
    logic [7:0]        lo_q;
    logic [15:0]       n_q, wcnt_q;
    logic [23:0]       word_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              last_wr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xor_q;
`endif

    // the pending write is the final one; state moves on the edge that retires it
    assign last_wr = we_q && (wcnt_q + 16'd1 == n_q);

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) state_q <= S_CNTL;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CNTL: if (rx_vld) state_d = S_CNTH;
            S_CNTH: if (rx_vld) begin
                if ({rx_byte, lo_q} == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_SUM;
`else
                    state_d = S_DONE;
`endif
                else
                    state_d = S_DATA;
            end
            S_DATA: if (last_wr)
`ifdef LOADER_CHECKSUM_EN
                state_d = S_SUM;
`else
                state_d = S_DONE;
`endif
`ifdef LOADER_CHECKSUM_EN
            S_SUM: if (rx_vld) state_d = (rx_byte == xor_q) ? S_DONE : S_ERR;
`endif
            default: state_d = state_q;
        endcase
        if (rx_fe && state_q != S_DONE && state_q != S_ERR) state_d = S_ERR;
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            bidx_q  <= '0;
            lo_q    <= '0;
            n_q     <= '0;
            wcnt_q  <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                addr_q <= addr_q + 1'b1;
                wcnt_q <= wcnt_q + 16'd1;
            end
            if (rx_vld) begin
                case (state_q)
                    S_CNTL: lo_q <= rx_byte;
                    S_CNTH: n_q  <= {rx_byte, lo_q};
                    S_DATA: begin
                        bidx_q <= bidx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        xor_q  <= xor_q ^ rx_byte;
`endif
                        if (bidx_q == BIDX_W'(3)) begin
                            we_q    <= 1'b1;
                            wdata_q <= {word_q, rx_byte};
                        end else begin
                            word_q  <= {word_q[15:0], rx_byte};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        r_we    = we_q;
        r_addr  = addr_q;
        r_wdata = wdata_q;
        r_busy  = (state_q != S_DONE);
        r_done  = (state_q == S_DONE);
        r_err   = (state_q == S_ERR);
    end
endmodule

// File: tb/tb_m_imem_loader.sv
// Self-checking bench for m_imem_loader: table vectors, timing corners, random streams vs. a stream model.
module tb_m_imem_loader;
    localparam int CPB = 4;
    localparam int AW  = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rxd = 1'b1;
    logic          we, busy, done, err;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;

    always #5 clk = ~clk;

    m_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .w_clk(clk), .w_rst_n(rst_n), .w_rxd(rxd),
        .r_we(we), .r_addr(addr), .r_wdata(wdata),
        .r_busy(busy), .r_done(done), .r_err(err)
    );

    int n_vec = 0;
    int n_mis = 0;

    logic [31:0] wr_addr[$], wr_data[$];
    logic [31:0] mq_addr[$], mq_data[$];
    logic        m_done, m_err;

    always @(negedge clk) if (we === 1'b1) begin
        wr_addr.push_back(32'(addr));
        wr_data.push_back(wdata);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; rxd = 1'b1;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic send_bit(input logic v);
        @(negedge clk); rxd = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(b[k]);
        send_bit(stop_ok);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic run_stream(input logic [7:0] bs[$], input int bad);
        for (int i = 0; i < bs.size(); i++) send_byte(bs[i], i != bad);
        repeat (20) @(negedge clk);
    endtask

    // Interprets the byte stream directly: header, then big-endian words, stop on error or completion.
    task automatic model(input logic [7:0] bs[$], input int bad);
        int n;
        logic [31:0] w;
        mq_addr.delete(); mq_data.delete();
        m_done = 1'b0; m_err = 1'b0; n = 0; w = '0;
        for (int i = 0; i < bs.size(); i++) begin
            if (m_done || m_err) break;
            if (i == bad) begin m_err = 1'b1; break; end
            if (i == 0) n = int'(bs[0]);
            else if (i == 1) begin
                n = n + 256 * int'(bs[1]);
                if (n == 0) m_done = 1'b1;
            end else begin
                w = {w[23:0], bs[i]};
                if ((i - 2) % 4 == 3) begin
                    mq_addr.push_back(32'(((i - 2) / 4) % (1 << AW)));
                    mq_data.push_back(w);
                    if ((i - 2) / 4 == n - 1) m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_exp(input string tag);
        chk({tag, " nwe"}, 32'(wr_data.size()), 32'(mq_data.size()));
        for (int k = 0; k < wr_data.size() && k < mq_data.size(); k++) begin
            chk($sformatf("%s addr%0d", tag, k), wr_addr[k], mq_addr[k]);
            chk($sformatf("%s data%0d", tag, k), wr_data[k], mq_data[k]);
        end
        chk({tag, " done"}, 32'(done), 32'(m_done));
        chk({tag, " busy"}, 32'(busy), 32'(!m_done));
        chk({tag, " err"},  32'(err),  32'(m_err));
    endtask

    typedef struct packed {
        logic [0:15][7:0] b;
        logic [4:0]       nb;
        logic [4:0]       bad;
        logic [2:0]       nwe;
        logic [0:3][31:0] w;
        logic             done;
        logic             err;
    } vec_t;

    vec_t tv[4];

    initial begin
        logic [7:0] bs[$];
        int bad, n;

        tv[0].b = {8'h01, 8'h00, 8'h20, 8'h14, 8'h00, 8'h00, 80'h0};
        tv[0].nb = 5'd6;  tv[0].bad = 5'h1f; tv[0].nwe = 3'd1;
        tv[0].w = {32'h20140000, 96'h0}; tv[0].done = 1'b1; tv[0].err = 1'b0;
        tv[1].b = {8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h20, 8'h14, 8'h00, 8'h0B,
                   8'h44, 8'h00, 8'h00, 8'h00, 16'h0};
        tv[1].nb = 5'd14; tv[1].bad = 5'h1f; tv[1].nwe = 3'd3;
        tv[1].w = {32'h00000020, 32'h2014000B, 32'h44000000, 32'h0};
        tv[1].done = 1'b1; tv[1].err = 1'b0;
        tv[2].b = {8'h00, 8'h00, 112'h0};
        tv[2].nb = 5'd2;  tv[2].bad = 5'h1f; tv[2].nwe = 3'd0;
        tv[2].w = '0; tv[2].done = 1'b1; tv[2].err = 1'b0;
        tv[3].b = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 48'h0};
        tv[3].nb = 5'd10; tv[3].bad = 5'd3; tv[3].nwe = 3'd0;
        tv[3].w = '0; tv[3].done = 1'b0; tv[3].err = 1'b1;

        do_reset();
        @(negedge clk);
        chk("rst we", 32'(we), 32'd0);
        chk("rst addr", 32'(addr), 32'd0);
        chk("rst wdata", wdata, 32'd0);
        chk("rst busy", 32'(busy), 32'd1);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            wr_addr.delete(); wr_data.delete();
            bs.delete();
            for (int k = 0; k < int'(tv[i].nb); k++) bs.push_back(tv[i].b[k]);
            bad = (tv[i].bad == 5'h1f) ? -1 : int'(tv[i].bad);
            run_stream(bs, bad);
            mq_addr.delete(); mq_data.delete();
            for (int k = 0; k < int'(tv[i].nwe); k++) begin
                mq_addr.push_back(32'(k));
                mq_data.push_back(tv[i].w[k]);
            end
            m_done = tv[i].done; m_err = tv[i].err;
            compare_exp($sformatf("tv%0d", i));
        end

        // N=0 timing: start bit reaches the pin before edge P0; 2-cycle sync, stop sample
        // 38 cycles after the synced edge, byte-valid one later, done one after that.
        do_reset();
        wr_addr.delete(); wr_data.delete();
        send_byte(8'h00, 1'b1);
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (j == 41) chk("n0 done early", 32'(done), 32'd0);
            if (j == 42) begin
                chk("n0 done on time", 32'(done), 32'd1);
                chk("n0 busy on time", 32'(busy), 32'd0);
            end
            rxd = (j < 36) ? 1'b0 : 1'b1;
        end
        chk("n0 nwe", 32'(wr_data.size()), 32'd0);

        // one-cycle glitch must not start a byte
        do_reset();
        wr_addr.delete(); wr_data.delete();
        @(negedge clk); rxd = 1'b0;
        @(negedge clk); rxd = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch nwe", 32'(wr_data.size()), 32'd0);
        chk("glitch busy", 32'(busy), 32'd1);
        chk("glitch done", 32'(done), 32'd0);
        bs = '{8'h01, 8'h00, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        run_stream(bs, -1);
        model(bs, -1);
        compare_exp("glitch");

        // reset mid-word discards the partial word and re-parses a header
        do_reset();
        wr_addr.delete(); wr_data.delete();
        bs = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        run_stream(bs, -1);
        do_reset();
        bs = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        run_stream(bs, -1);
        model(bs, -1);
        compare_exp("midrst");

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            bs.delete();
            bs.push_back(8'(n));
            bs.push_back(8'h00);
            for (int k = 0; k < 4 * n; k++) bs.push_back(8'($urandom));
            bad = ($urandom_range(0, 2) == 0) ? $urandom_range(0, bs.size() - 1) : -1;
            do_reset();
            wr_addr.delete(); wr_data.delete();
            run_stream(bs, bad);
            model(bs, bad);
            compare_exp($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/m_imem_loader.md
# m_imem_loader

Serial program loader for the five-stage processor. Receives an 8N1 UART byte stream from a host, assembles big-endian 32-bit instruction words, and writes them word-by-word into instruction memory through a one-cycle write port, starting at word address 0. It holds the processor in reset while loading and releases it once the programmed word count has been written.

## Interface
- CLKS_PER_BIT, 434: clock cycles per UART bit, for 50 MHz / 115200 baud; legal values are ≥ 4.
- ADDR_W, 12: word-address width of the instruction memory.
- w_clk  in  1  system clock.
- w_rst_n  in  1  reset; one clock, synchronous, active-low.
- w_rxd  in  1  asynchronous UART receive line; idles high.
- r_we  out  1  memory write strobe, one cycle per word.
- r_addr  out  ADDR_W  word address of the current write.
- r_wdata  out  32  instruction word.
- r_busy  out  1  hold processor in reset while high.
- r_done  out  1  load complete; sticky.
- r_err  out  1  framing (or checksum) error; sticky.

## Operation
- w_rxd passes through a 2-flop synchronizer before any use.
- Receiver:
  - A falling edge arms a counter; at CLKS_PER_BIT/2 the start bit is re-sampled.
  - If the re-sampled start bit is high, the edge was a glitch: return to idle with no byte.
  - Otherwise sample 8 data bits LSB-first every CLKS_PER_BIT, then the stop bit.
  - Stop bit = 1: one-cycle byte-valid pulse. Stop bit = 0: one-cycle framing-error pulse.
- Stream format: count_lo, count_hi (16-bit word count N), then N×4 data bytes, most significant byte first.
- Loader FSM states: S_CNTL → S_CNTH → S_DATA (byte index 0..3) → S_DONE; any state → S_ERR on a framing error.
  - S_CNTH with N = 0 goes directly to S_DONE.
  - S_DATA: on the 4th byte, r_wdata is updated and r_we is pulsed; r_addr increments after each write.
  - S_DATA → S_DONE after the Nth write.
  - S_DONE and S_ERR are terminal until reset. Bytes received in these states are ignored.
- N > 2^ADDR_W: r_addr wraps modulo 2^ADDR_W and later words overwrite earlier ones; no error is raised.
- Reset values: r_we=0, r_addr=0, r_wdata=0, r_busy=1, r_done=0, r_err=0. Receiver and FSM return to idle / S_CNTL.
- Reset mid-load: a partially assembled word is discarded. Memory contents are not cleared. The next bytes are parsed as a fresh header.
- r_busy = 0 only in S_DONE. In S_ERR the processor stays held.

## Timing
- Synchronizer latency is 2 cycles.
- Stop bit is sampled 9.5×CLKS_PER_BIT cycles after the synchronized falling edge.
- Byte-valid rises the cycle after the stop-bit sample.
- r_we, r_addr and r_wdata are registered and valid together in the cycle after the 4th byte-valid. r_addr increments on the following edge.
- r_done and r_busy change in the cycle after the last r_we. For N = 0, they change in the cycle after the count_hi byte-valid.
- r_err rises the cycle after the framing-error pulse.
- No back-pressure: the memory write port is assumed to always accept a write.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - Adds state S_SUM after the last data byte.
  - The host sends one byte equal to the XOR of all data bytes; header bytes are excluded.
  - Match → S_DONE. Mismatch → S_ERR with r_err=1 and r_busy kept at 1.
  - For N = 0, the checksum byte is still expected and must be 0x00.
- LOADER_CHECKSUM_EN undefined: no S_SUM state and no XOR register; S_DATA goes directly to S_DONE.

## Structure
- Package loader_pkg holds:
  - the FSM state encoding (S_CNTL, S_CNTH, S_DATA, S_SUM, S_DONE, S_ERR);
  - the receiver state encoding (R_IDLE, R_START, R_DATA, R_STOP);
  - the byte-index width constant.
- Sub-module m_uart_rx contains the synchronizer, the bit-timing counter and the shift register.
  - Outputs: byte[7:0], byte-valid pulse, framing-error pulse.
  - The word assembler and FSM stay in m_imem_loader.

## Test plan
All scenarios run with CLKS_PER_BIT=4 and ADDR_W=12.
- Byte stream 01 00 20 14 00 00 → one r_we with r_addr=0, r_wdata=0x20140000; then r_done=1, r_busy=0, r_err=0.
- N=3 with words 0x00000020, 0x2014000B, 0x44000000 → three r_we pulses at r_addr 0, 1, 2 with matching r_wdata; r_done asserted after the third pulse.
- Stream 00 00 → no r_we; r_done=1 the cycle after the second byte-valid.
- Stop bit driven low on the 2nd data byte → r_err=1, r_busy stays 1, no further r_we even if valid bytes follow.
- w_rxd pulsed low for 1 cycle, then held high → no byte-valid and no state change.
- w_rst_n low for 1 cycle after 2 data bytes of word 0, then a complete one-word stream → exactly one r_we at r_addr=0 carrying the new word.
